id_ex_pipe_reg: RTL

ID/EX pipeline stage that sits directly downstream of the control unit. It registers the decoded control bundle, register specifiers and operands into the EX stage. It detects load-use hazards against the instruction currently in EX and converts the EX slot into a bubble on a stall or a taken-branch flush. It also drives the PC/IF-ID write enables that freeze the front end.

---
 rtl/id_ex_pipe_reg.sv | 120 ++++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional stall/flush event counters are built when STALL_CNT_EN is defined.
module id_ex_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reg_dst_in,
   input  logic              reg_write_in,
   input  logic              alu_src_in,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic              mem_to_reg_in,
   input  logic              branch_in,
   input  logic              jump_in,
   input  logic [2:0]        alu_op_in,
   input  logic [4:0]        rs_in,
   input  logic [4:0]        rt_in,
   input  logic [4:0]        rd_in,
   input  logic [DATA_W-1:0] rd1_in,
   input  logic [DATA_W-1:0] rd2_in,
   input  logic [DATA_W-1:0] imm_in,
   input  logic              branchtaken,
   output logic              reg_dst_ex,
   output logic              reg_write_ex,
   output logic              alu_src_ex,
   output logic              mem_read_ex,
   output logic              mem_write_ex,
   output logic              mem_to_reg_ex,
   output logic              branch_ex,
   output logic              jump_ex,
   output logic [2:0]        alu_op_ex,
   output logic [4:0]        rs_ex,
   output logic [4:0]        rt_ex,
   output logic [4:0]        rd_ex,
   output logic [DATA_W-1:0] rd1_ex,
   output logic [DATA_W-1:0] rd2_ex,
   output logic [DATA_W-1:0] imm_ex,
   output logic              valid_ex,
   output logic              stall,
   output logic              pc_write,
   output logic              ifid_write
`ifdef STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   logic hazard;
   logic bubble;

   // A load targeting $zero never creates a real dependence.
   assign hazard = mem_read_ex & valid_ex & (rt_ex != 5'd0) &
                   ((rt_ex == rs_in) | (rt_ex == rt_in));
   // The ID instruction is wrong-path under a taken branch, so no stall.
   assign stall      = hazard & ~branchtaken;
   assign pc_write   = ~stall;
   assign ifid_write = ~stall;
   assign bubble     = branchtaken | stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst || bubble) begin
         reg_dst_ex    <= 1'b0;
         reg_write_ex  <= 1'b0;
         alu_src_ex    <= 1'b0;
         mem_read_ex   <= 1'b0;
         mem_write_ex  <= 1'b0;
         mem_to_reg_ex <= 1'b0;
         branch_ex     <= 1'b0;
         jump_ex       <= 1'b0;
         alu_op_ex     <= 3'b000;
         rs_ex         <= 5'd0;
         rt_ex         <= 5'd0;
         rd_ex         <= 5'd0;
         rd1_ex        <= '0;
         rd2_ex        <= '0;
         imm_ex        <= '0;
         valid_ex      <= 1'b0;
      end else begin
         reg_dst_ex    <= reg_dst_in;
         reg_write_ex  <= reg_write_in;
         alu_src_ex    <= alu_src_in;
         mem_read_ex   <= mem_read_in;
         mem_write_ex  <= mem_write_in;
         mem_to_reg_ex <= mem_to_reg_in;
         branch_ex     <= branch_in;
         jump_ex       <= jump_in;
         alu_op_ex     <= alu_op_in;
         rs_ex         <= rs_in;
         rt_ex         <= rt_in;
         rd_ex         <= rd_in;
         rd1_ex        <= rd1_in;
         rd2_ex        <= rd2_in;
         imm_ex        <= imm_in;
         valid_ex      <= 1'b1;
      end
   end

`ifdef STALL_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Counters saturate at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
         if (branchtaken && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_ONE;
         end
      end
   end
`endif

endmodule
